// File: rtl/traffic_intersection.sv
// Round-robin multi-approach traffic controller with latched pedestrian
// requests and a flashing-yellow maintenance mode. All outputs are decoded
// from registered state only.
module traffic_intersection #(
    parameter int NUM_DIR          = 2,
    parameter int CYCLE_ALL_RED    = 2,
    parameter int CYCLE_RED_YELLOW = 2,
    parameter int CYCLE_GREEN      = 5,
    parameter int CYCLE_YELLOW     = 2,
    parameter int FLASH_PERIOD     = 4,
    parameter int TIME_WIDTH       = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       flash_mode,
    input  logic [NUM_DIR-1:0]         ped_req,
    output logic [NUM_DIR-1:0]         red,
    output logic [NUM_DIR-1:0]         yellow,
    output logic [NUM_DIR-1:0]         green,
    output logic [NUM_DIR-1:0]         walk,
    output logic [$clog2(NUM_DIR)-1:0] active_dir
);
    localparam int DW = $clog2(NUM_DIR);

    // Reload values: a phase of length C starts its down-counter at C-1.
    localparam logic [TIME_WIDTH-1:0] T_AR = TIME_WIDTH'(CYCLE_ALL_RED - 1);
    localparam logic [TIME_WIDTH-1:0] T_RY = TIME_WIDTH'(CYCLE_RED_YELLOW - 1);
    localparam logic [TIME_WIDTH-1:0] T_G  = TIME_WIDTH'(CYCLE_GREEN - 1);
    localparam logic [TIME_WIDTH-1:0] T_Y  = TIME_WIDTH'(CYCLE_YELLOW - 1);
    localparam logic [TIME_WIDTH-1:0] T_FP = TIME_WIDTH'(FLASH_PERIOD - 1);

    localparam logic [NUM_DIR-1:0] ONE     = NUM_DIR'(1);
    localparam logic [DW-1:0]      LAST_DIR = DW'(NUM_DIR - 1);

    // Elaboration-time sanity on the parameter set.
    if (NUM_DIR < 2) begin : g_chk_dir
        $error("NUM_DIR must be at least 2");
    end
    if (CYCLE_ALL_RED < 1 || CYCLE_RED_YELLOW < 1 || CYCLE_GREEN < 1 ||
        CYCLE_YELLOW < 1 || FLASH_PERIOD < 1) begin : g_chk_len
        $error("all phase lengths must be at least 1");
    end

    typedef enum logic [2:0] {
        ALL_RED,
        RED_YELLOW,
        GREEN,
        YELLOW,
        FLASH
    } state_t;

    state_t                 state, state_nxt;
    logic [TIME_WIDTH-1:0]  timer, timer_nxt;
    logic [DW-1:0]          dir_nxt;
    logic                   blink, blink_nxt;
    logic                   walk_arm, walk_arm_nxt;
    logic [NUM_DIR-1:0]     ped_pend, pend_nxt;
    logic [NUM_DIR-1:0]     dir_oh;

    // State register; reset aborts any phase immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ALL_RED;
            timer      <= T_AR;
            active_dir <= '0;
            blink      <= 1'b0;
            walk_arm   <= 1'b0;
            ped_pend   <= '0;
        end else begin
            state      <= state_nxt;
            timer      <= timer_nxt;
            active_dir <= dir_nxt;
            blink      <= blink_nxt;
            walk_arm   <= walk_arm_nxt;
            ped_pend   <= pend_nxt;
        end
    end

    // Next-state logic: phase sequencing, flash entry/exit, pedestrian latch.
    always_comb begin
        state_nxt    = state;
        timer_nxt    = timer;
        dir_nxt      = active_dir;
        blink_nxt    = blink;
        walk_arm_nxt = walk_arm;
        // Requests are latched every cycle, even while frozen.
        pend_nxt     = ped_pend | ped_req;

        if (en) begin
            unique case (state)
                ALL_RED: begin
                    if (flash_mode) begin
                        state_nxt = FLASH;
                        timer_nxt = T_FP;
                        blink_nxt = 1'b1;
                    end else if (timer == '0) begin
                        state_nxt = RED_YELLOW;
                        timer_nxt = T_RY;
                    end else begin
                        timer_nxt = timer - 1'b1;
                    end
                end
                RED_YELLOW: begin
                    if (flash_mode) begin
                        state_nxt = FLASH;
                        timer_nxt = T_FP;
                        blink_nxt = 1'b1;
                    end else if (timer == '0) begin
                        // Green entry: a request on this very cycle is served now.
                        state_nxt              = GREEN;
                        timer_nxt              = T_G;
                        walk_arm_nxt           = pend_nxt[active_dir];
                        pend_nxt[active_dir]   = 1'b0;
                    end else begin
                        timer_nxt = timer - 1'b1;
                    end
                end
                GREEN: begin
                    // Flash cuts green short but still passes through a full yellow.
                    if (flash_mode || timer == '0) begin
                        state_nxt = YELLOW;
                        timer_nxt = T_Y;
                    end else begin
                        timer_nxt = timer - 1'b1;
                    end
                end
                YELLOW: begin
                    if (timer == '0) begin
                        dir_nxt = (active_dir == LAST_DIR) ? '0 : active_dir + 1'b1;
                        if (flash_mode) begin
                            state_nxt = FLASH;
                            timer_nxt = T_FP;
                            blink_nxt = 1'b1;
                        end else begin
                            state_nxt = ALL_RED;
                            timer_nxt = T_AR;
                        end
                    end else begin
                        timer_nxt = timer - 1'b1;
                    end
                end
                FLASH: begin
                    if (!flash_mode) begin
                        state_nxt = ALL_RED;
                        timer_nxt = T_AR;
                    end else if (timer == '0) begin
                        blink_nxt = ~blink;
                        timer_nxt = T_FP;
                    end else begin
                        timer_nxt = timer - 1'b1;
                    end
                end
                default: begin
                    state_nxt = ALL_RED;
                    timer_nxt = T_AR;
                end
            endcase
        end
    end

    // Lamp and walk decode from registered state.
    always_comb begin
        dir_oh = ONE << active_dir;
        red    = '1;
        yellow = '0;
        green  = '0;
        walk   = '0;
        unique case (state)
            ALL_RED: begin
                red = '1;
            end
            RED_YELLOW: begin
                yellow = dir_oh;
            end
            GREEN: begin
                red   = ~dir_oh;
                green = dir_oh;
                walk  = walk_arm ? dir_oh : '0;
            end
            YELLOW: begin
                red    = ~dir_oh;
                yellow = dir_oh;
            end
            FLASH: begin
                red    = '0;
                yellow = {NUM_DIR{blink}};
            end
            default: begin
                red = '1;
            end
        endcase
    end
endmodule

// File: doc/traffic_intersection.md
# traffic_intersection

Parametrised multi-approach traffic controller: it serves `NUM_DIR` approaches in round-robin order through all-red, red+yellow, green and yellow phases. It latches pedestrian requests per approach and drives a walk signal during that approach's green. It has a flashing-yellow maintenance mode. It sits at the top of the signal-control datapath and drives the per-approach lamp drivers directly.

## Interface
- `NUM_DIR`, 2: number of approaches; must be at least 2.
- `CYCLE_ALL_RED`, 2: length of the all-red clearance phase, in enabled cycles; must be at least 1.
- `CYCLE_RED_YELLOW`, 2: length of the red+yellow phase, in enabled cycles; must be at least 1.
- `CYCLE_GREEN`, 5: length of the green phase, in enabled cycles; must be at least 1.
- `CYCLE_YELLOW`, 2: length of the yellow phase, in enabled cycles; must be at least 1.
- `FLASH_PERIOD`, 4: enabled cycles per on or off half-period in flash mode; must be at least 1.
- `TIME_WIDTH`, 4: phase timer width; must hold `max(CYCLE_*, FLASH_PERIOD)-1`.
- `clk` input 1: clock. One clock only.
- `rst` input 1: reset, asynchronous and active-high.
- `en` input 1: advance enable. When low, the timer, state and blink are all frozen.
- `flash_mode` input 1: request for flashing-yellow mode; level-sensitive.
- `ped_req` input `NUM_DIR`: per-approach pedestrian request; a single-cycle pulse is sufficient.
- `red`, `yellow`, `green` output `NUM_DIR` each: lamp drives, one bit per approach.
- `walk` output `NUM_DIR`: pedestrian walk indication, one bit per approach.
- `active_dir` output `$clog2(NUM_DIR)`: the approach currently being served.

## Operation
- **States:** ALL_RED, RED_YELLOW, GREEN, YELLOW, FLASH.
- **Phase timer:** loaded with `C-1` on entry to a phase of length `C`. It decrements on each enabled cycle. The phase exits on an enabled cycle where the timer is 0. Each phase therefore lasts exactly `C` enabled cycles.
- **Normal sequence:** ALL_RED → RED_YELLOW → GREEN → YELLOW → ALL_RED.
- **Direction advance:** on the YELLOW → ALL_RED transition, `active_dir` increments. It wraps from `NUM_DIR-1` to 0.
- **Lamps, non-active approaches:** outside FLASH, every non-active approach shows `red=1` only.
- **Lamps, active approach:**
  - ALL_RED: red.
  - RED_YELLOW: red and yellow.
  - GREEN: green.
  - YELLOW: yellow.
- **Flash entry** (`flash_mode=1` sampled on an enabled cycle):
  - From ALL_RED or RED_YELLOW: go to FLASH next cycle; `active_dir` unchanged.
  - From GREEN: go to YELLOW next cycle, with the timer loaded with `CYCLE_YELLOW-1`.
  - From YELLOW: the yellow phase completes, then the state goes to FLASH instead of ALL_RED. `active_dir` still advances.
- **FLASH lamps:** all `red` and `green` bits are 0. All `yellow` bits equal the blink bit.
- **Blink bit:** set to 1 on FLASH entry. It toggles every `FLASH_PERIOD` enabled cycles.
- **Flash exit:** `flash_mode=0` on an enabled cycle in FLASH → ALL_RED next cycle, with the full `CYCLE_ALL_RED`.
- **Pedestrian pending flags:**
  - `ped_pend[d]` is set on any cycle where `ped_req[d]=1`, regardless of `en` or state.
  - On entry to GREEN for approach `d`: `walk_arm` ← `ped_pend[d] | ped_req[d]`, and `ped_pend[d]` is cleared.
  - A request arriving during approach `d`'s own GREEN, after entry, stays pending for the next service of `d`.
- **Walk output:** `walk[d]=1` only when the state is GREEN, `active_dir==d` and `walk_arm=1`. `walk` is 0 in all other states, including FLASH.
- **Pending flags and flash:** `ped_pend` is held through FLASH, not cleared.
- **Enable low:** state, timer, blink and `active_dir` hold, and the outputs hold.

## Timing
- **Output decode:** all outputs are decoded combinationally from registered state only, so they are glitch-free. They change in the same cycle as the state register updates.
- **Reset values** (immediately on `rst` assertion, asynchronous):
  - state ALL_RED, timer `CYCLE_ALL_RED-1`, `active_dir=0`.
  - `ped_pend=0`, `walk_arm=0`, blink=0.
  - `red` all 1; `yellow`, `green` and `walk` all 0.
- **Reset mid-operation:** a reset asserted in any state aborts the phase immediately, with no yellow completion.
- **Reset release:** the first enabled rising edge after `rst` deasserts counts as ALL_RED cycle 1.
- **Full rotation length:** `NUM_DIR × (CYCLE_ALL_RED + CYCLE_RED_YELLOW + CYCLE_GREEN + CYCLE_YELLOW)` enabled cycles. With the defaults this is 22.
- **Simultaneous events:**
  - `flash_mode` has priority over a timer expiry in the same cycle.
  - `ped_req[d]` on the GREEN-entry cycle for `d` is served in that green.

## Test plan
- **Reset release, defaults, `en=1`:** cycles 0–1 all red; 2–3 dir0 red+yellow; 4–8 `green[0]`; 9–10 `yellow[0]`; 11–12 all red with `active_dir=1`; 15–19 `green[1]`; cycle 22 back to dir0 all-red.
- **Pedestrian request:** `ped_req[1]` pulsed at cycle 3 → `walk[1]=1` exactly in cycles 15–19. `walk[0]` stays 0, and there is no walk on the following rotation.
- **Enable stall:** `en=0` for 3 cycles at cycle 5 → `green[0]` is visible for 8 cycles and all later transitions shift by 3.
- **Flash mode:**
  - Setup: `flash_mode=1` at cycle 6, during GREEN.
  - Cycles 7–8: `yellow[0]`.
  - From cycle 9: FLASH, with `yellow=2'b11` for 4 cycles, then `2'b00` for 4 cycles, repeating.
  - Releasing `flash_mode` → ALL_RED for 2 cycles, then dir1 red+yellow.
- **Reset mid-green:** `rst` pulsed at cycle 6, with `ped_pend` set → outputs go all red in the same cycle, `active_dir=0` and `ped_pend=0`. The sequence then restarts exactly as in the first scenario.
- **Wrap-around, `NUM_DIR=3`:** after dir2's YELLOW, `active_dir` wraps to 0, and `green[0]` reappears 33 cycles after its first occurrence.
